ctrl_issue_unit: RTL

Parametrised successor to the ID-stage control decoder. It decodes mode, opcode and S into execute/memory/writeback controls, and evaluates the 4-bit condition field against an internal NZCV status register. Results go into a registered ID/EX control stage that supports stall, flush and multi-cycle memory hold. It sits between the ID register file read and the EX stage of the pipelined core.

---
 rtl/ctrl_issue_if.sv | 36 +++
 rtl/ctrl_issue_unit.sv | 136 +++++++++++++
 2 files changed

// File: rtl/ctrl_issue_if.sv
// ID -> EX control handshake bundle for ctrl_issue_unit.
// id_ready is the only backpressure: ID advances on any cycle where id_ready is 1.
interface ctrl_issue_if #(
  parameter int CMD_W = 4
);
  logic             id_valid;
  logic [1:0]       mode;
  logic [3:0]       opcode;
  logic             s_in;
  logic [3:0]       cond;
  logic [3:0]       flags_in;
  logic             flags_we;
  logic             hazard;
  logic             flush;
  logic             id_ready;
  logic             ex_valid;
  logic [CMD_W-1:0] ex_cmd;
  logic             ex_mem_r;
  logic             ex_mem_w;
  logic             ex_wb_en;
  logic             ex_b_en;
  logic             ex_s_en;
  logic [3:0]       status;

  modport master (
    output id_valid, mode, opcode, s_in, cond, flags_in, flags_we, hazard, flush,
    input  id_ready, ex_valid, ex_cmd, ex_mem_r, ex_mem_w, ex_wb_en, ex_b_en,
           ex_s_en, status
  );

  modport slave (
    input  id_valid, mode, opcode, s_in, cond, flags_in, flags_we, hazard, flush,
    output id_ready, ex_valid, ex_cmd, ex_mem_r, ex_mem_w, ex_wb_en, ex_b_en,
           ex_s_en, status
  );
endinterface

// File: rtl/ctrl_issue_unit.sv
// ID-stage decode, NZCV condition check and registered ID/EX control stage.
// Optional macro COND_FWD_EN: evaluate conditions on same-cycle flags_in when flags_we=1.
module ctrl_issue_unit #(
  parameter int CMD_W   = 4,
  parameter int MEM_LAT = 2,
  parameter int CNT_W   = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  ctrl_issue_if.slave  bus
);
  logic [3:0]       cmd_d;
  logic             mr_d, mw_d, wb_d, b_d, s_d, is_mem;
  logic [3:0]       f;
  logic             cond_ok;
  logic [CNT_W-1:0] cnt;
  logic [3:0]       status_q;

`ifdef COND_FWD_EN
  assign f = bus.flags_we ? bus.flags_in : status_q;
`else
  assign f = status_q;
`endif

  // f = {N, Z, C, V}
  always_comb begin
    cond_ok = 1'b0;
    unique case (bus.cond)
      4'b0000: cond_ok = f[2];
      4'b0001: cond_ok = ~f[2];
      4'b0010: cond_ok = f[1];
      4'b0011: cond_ok = ~f[1];
      4'b0100: cond_ok = f[3];
      4'b0101: cond_ok = ~f[3];
      4'b0110: cond_ok = f[0];
      4'b0111: cond_ok = ~f[0];
      4'b1000: cond_ok = f[1] & ~f[2];
      4'b1001: cond_ok = ~f[1] | f[2];
      4'b1010: cond_ok = (f[3] == f[0]);
      4'b1011: cond_ok = (f[3] != f[0]);
      4'b1100: cond_ok = ~f[2] & (f[3] == f[0]);
      4'b1101: cond_ok = f[2] | (f[3] != f[0]);
      4'b1110: cond_ok = 1'b1;
      default: cond_ok = 1'b0;
    endcase
  end

  always_comb begin
    cmd_d  = 4'b0000;
    mr_d   = 1'b0;
    mw_d   = 1'b0;
    wb_d   = 1'b0;
    b_d    = 1'b0;
    s_d    = 1'b0;
    is_mem = 1'b0;
    unique case (bus.mode)
      2'b00: begin
        s_d = bus.s_in;
        wb_d = 1'b1;
        unique case (bus.opcode)
          4'b1101: cmd_d = 4'b0001;
          4'b1111: cmd_d = 4'b1001;
          4'b0100: cmd_d = 4'b0010;
          4'b0101: cmd_d = 4'b0011;
          4'b0010: cmd_d = 4'b0100;
          4'b0110: cmd_d = 4'b0101;
          4'b0000: cmd_d = 4'b0110;
          4'b1100: cmd_d = 4'b0111;
          4'b0001: cmd_d = 4'b1000;
          4'b1010: begin cmd_d = 4'b0100; wb_d = 1'b0; s_d = 1'b1; end
          4'b1000: begin cmd_d = 4'b0110; wb_d = 1'b0; s_d = 1'b1; end
          default: begin wb_d = 1'b0; s_d = 1'b0; end
        endcase
      end
      2'b01: begin
        is_mem = 1'b1;
        cmd_d  = 4'b0010;
        mr_d   = bus.s_in;
        wb_d   = bus.s_in;
        mw_d   = ~bus.s_in;
      end
      2'b10:   b_d = 1'b1;
      default: ;
    endcase
    // A failed condition still occupies EX, just with every control killed.
    if (!cond_ok) begin
      cmd_d = 4'b0000;
      mr_d  = 1'b0;
      mw_d  = 1'b0;
      wb_d  = 1'b0;
      b_d   = 1'b0;
      s_d   = 1'b0;
    end
  end

  assign bus.id_ready = bus.flush | ((cnt == '0) & ~bus.hazard);
  assign bus.status   = status_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) status_q <= 4'b0000;
    else if (bus.flags_we) status_q <= bus.flags_in;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt          <= '0;
      bus.ex_valid <= 1'b0;
      bus.ex_cmd   <= '0;
      bus.ex_mem_r <= 1'b0;
      bus.ex_mem_w <= 1'b0;
      bus.ex_wb_en <= 1'b0;
      bus.ex_b_en  <= 1'b0;
      bus.ex_s_en  <= 1'b0;
    end else if (bus.flush || (cnt == '0 && (bus.hazard || !bus.id_valid))) begin
      cnt          <= '0;
      bus.ex_valid <= 1'b0;
      bus.ex_cmd   <= '0;
      bus.ex_mem_r <= 1'b0;
      bus.ex_mem_w <= 1'b0;
      bus.ex_wb_en <= 1'b0;
      bus.ex_b_en  <= 1'b0;
      bus.ex_s_en  <= 1'b0;
    end else if (cnt != '0) begin
      cnt <= cnt - 1'b1;
    end else begin
      bus.ex_valid <= 1'b1;
      bus.ex_cmd   <= CMD_W'(cmd_d);
      bus.ex_mem_r <= mr_d;
      bus.ex_mem_w <= mw_d;
      bus.ex_wb_en <= wb_d;
      bus.ex_b_en  <= b_d;
      bus.ex_s_en  <= s_d;
      if (is_mem && cond_ok) cnt <= CNT_W'(MEM_LAT - 1);
    end
  end
endmodule
